// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter sharing one combinational ALU between two ports.
// Define ALU_ARB_OPCHECK_EN to flag illegal opcodes via resp_err_* and zero their result.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [3:0]        req_op_0,
    input  logic [3:0]        req_op_1,
    output logic              resp_valid_0,
    output logic              resp_valid_1,
    input  logic              resp_ready_0,
    input  logic              resp_ready_1,
    output logic [DATA_W-1:0] resp_result_0,
    output logic [DATA_W-1:0] resp_result_1,
    output logic              resp_err_0,
    output logic              resp_err_1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result
);

    logic              pri;
    logic              elig_0;
    logic              elig_1;
    logic              grant_0;
    logic              grant_1;
    logic              illegal;
    logic [DATA_W-1:0] cap_result;

    // A slot can take a new result if it is empty or being drained now.
    assign elig_0 = !resp_valid_0 || resp_ready_0;
    assign elig_1 = !resp_valid_1 || resp_ready_1;

    assign req_ready_0 = elig_0 && (!pri || !(req_valid_1 && elig_1));
    assign req_ready_1 = elig_1 && (pri || !(req_valid_0 && elig_0));

    assign grant_0 = req_valid_0 && req_ready_0;
    assign grant_1 = req_valid_1 && req_ready_1;

    always_comb begin
        alu_a  = req_a_0;
        alu_b  = req_b_0;
        alu_op = req_op_0;
        if (grant_1 || (!grant_0 && pri)) begin
            alu_a  = req_a_1;
            alu_b  = req_b_1;
            alu_op = req_op_1;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic err_0_q;
    logic err_1_q;

    always_comb begin
        illegal = 1'b1;
        case (alu_op)
            4'b0000, 4'b1000, 4'b0001, 4'b0100,
            4'b0101, 4'b1101, 4'b0110, 4'b0111: illegal = 1'b0;
            default:                            illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_0_q <= 1'b0;
            err_1_q <= 1'b0;
        end else begin
            if (grant_0) err_0_q <= illegal;
            if (grant_1) err_1_q <= illegal;
        end
    end

    assign resp_err_0 = err_0_q;
    assign resp_err_1 = err_1_q;
`else
    assign illegal    = 1'b0;
    assign resp_err_0 = 1'b0;
    assign resp_err_1 = 1'b0;
`endif

    assign cap_result = illegal ? '0 : alu_result;

    // Grant and drain on the same port keep valid high: new result replaces old.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri           <= 1'b0;
            resp_valid_0  <= 1'b0;
            resp_valid_1  <= 1'b0;
            resp_result_0 <= '0;
            resp_result_1 <= '0;
        end else begin
            if (grant_0) begin
                resp_result_0 <= cap_result;
                resp_valid_0  <= 1'b1;
            end else if (resp_ready_0) begin
                resp_valid_0  <= 1'b0;
            end
            if (grant_1) begin
                resp_result_1 <= cap_result;
                resp_valid_1  <= 1'b1;
            end else if (resp_ready_1) begin
                resp_valid_1  <= 1'b0;
            end
            if (grant_0) begin
                pri <= 1'b1;
            end else if (grant_1) begin
                pri <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural shared ALU.
// Inputs change on the falling edge; outputs are sampled #1 after either edge.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [3:0]  req_op_0, req_op_1;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0, resp_ready_1;
    logic [31:0] resp_result_0, resp_result_1;
    logic        resp_err_0, resp_err_1;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
        .resp_result_0(resp_result_0), .resp_result_1(resp_result_1),
        .resp_err_0(resp_err_0), .resp_err_1(resp_err_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result)
    );

    // Shared ALU; illegal codes return a recognisable marker.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b1000: alu_result = alu_a - alu_b;
            4'b0001: alu_result = alu_a << alu_b[4:0];
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = alu_a >> alu_b[4:0];
            4'b1101: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b0110: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_a & alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sra_exp [4];
    logic [31:0] bad_res;
    logic [31:0] bad_err;

    initial begin
        sra_exp[0] = 32'hC000_0000;
        sra_exp[1] = 32'hE000_0000;
        sra_exp[2] = 32'hF000_0000;
        sra_exp[3] = 32'hF800_0000;
`ifdef ALU_ARB_OPCHECK_EN
        bad_res = 32'h0;
        bad_err = 32'h1;
`else
        bad_res = 32'hDEAD_BEEF;
        bad_err = 32'h0;
`endif

        // Reset held two cycles with both ports requesting
        rst = 1'b1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        req_a_0 = 32'd5; req_b_0 = 32'd3; req_op_0 = 4'b0000;
        req_a_1 = 32'd9; req_b_1 = 32'd4; req_op_1 = 4'b1000;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            after_pos();
            check("rst_v0", 32'(resp_valid_0), 32'd0);
            check("rst_v1", 32'(resp_valid_1), 32'd0);
        end
        check("rst_res0", resp_result_0, 32'd0);
        check("rst_res1", resp_result_1, 32'd0);
        check("rst_err0", 32'(resp_err_0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Contention: grants alternate starting with port 0
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ctn_rdy0", 32'(req_ready_0), 32'(i % 2 == 0));
            check("ctn_rdy1", 32'(req_ready_1), 32'(i % 2 == 1));
            after_pos();
            if (i % 2 == 0) begin
                check("ctn_v0", 32'(resp_valid_0), 32'd1);
                check("ctn_res0", resp_result_0, 32'd8);
            end else begin
                check("ctn_v1", 32'(resp_valid_1), 32'd1);
                check("ctn_res1", resp_result_1, 32'd5);
            end
            @(negedge clk);
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        after_pos();
        check("drain_v0", 32'(resp_valid_0), 32'd0);
        check("drain_v1", 32'(resp_valid_1), 32'd0);
        @(negedge clk);

        // Backpressure on port 0
        req_a_0 = 32'hF0; req_b_0 = 32'h3C; req_op_0 = 4'b0111;
        resp_ready_0 = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        check("bp_rdy0_first", 32'(req_ready_0), 32'd1);
        after_pos();
        check("bp_res0", resp_result_0, 32'h30);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy0_low", 32'(req_ready_0), 32'd0);
            check("bp_rdy1_high", 32'(req_ready_1), 32'd1);
            after_pos();
            check("bp_hold_v0", 32'(resp_valid_0), 32'd1);
            check("bp_hold_res0", resp_result_0, 32'h30);
            check("bp_res1", resp_result_1, 32'd5);
            @(negedge clk);
        end
        resp_ready_0 = 1'b1;
        req_a_0 = 32'hFF;
        #1;
        check("bp_reenable0", 32'(req_ready_0), 32'd1);
        check("bp_block1", 32'(req_ready_1), 32'd0);
        after_pos();
        check("bp_replace_v0", 32'(resp_valid_0), 32'd1);
        check("bp_replace_res0", resp_result_0, 32'h3C);
        @(negedge clk);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        after_pos();
        @(negedge clk);

        // Port 1 alone at full rate
        req_valid_1 = 1'b1;
        req_a_1 = 32'h8000_0000; req_op_1 = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            req_b_1 = 32'(i + 1);
            #1;
            check("tp_rdy1", 32'(req_ready_1), 32'd1);
            after_pos();
            check("tp_v1", 32'(resp_valid_1), 32'd1);
            check("tp_res1", resp_result_1, sra_exp[i]);
            @(negedge clk);
        end
        req_valid_1 = 1'b0;
        #1;
        check("idle_alu_a", alu_a, 32'hFF);
        check("idle_alu_op", 32'(alu_op), 32'b0111);

        // Opcode check on port 0
        req_valid_0 = 1'b1;
        req_a_0 = 32'd7; req_b_0 = 32'd3; req_op_0 = 4'b0010;
        #1;
        check("op_alu_op", 32'(alu_op), 32'b0010);
        after_pos();
        check("op_bad_res0", resp_result_0, bad_res);
        check("op_bad_err0", 32'(resp_err_0), bad_err);
        @(negedge clk);
        req_op_0 = 4'b0000;
        after_pos();
        check("op_good_res0", resp_result_0, 32'd10);
        check("op_good_err0", 32'(resp_err_0), 32'd0);
        @(negedge clk);
        req_valid_0 = 1'b0;
        after_pos();
        @(negedge clk);

        // Reset while port 1 holds a response and pri favours port 1
        req_valid_1 = 1'b1; resp_ready_1 = 1'b0;
        req_a_1 = 32'd1; req_b_1 = 32'd2; req_op_1 = 4'b0000;
        after_pos();
        check("rh_v1", 32'(resp_valid_1), 32'd1);
        check("rh_res1", resp_result_1, 32'd3);
        @(negedge clk);
        req_valid_1 = 1'b0; req_valid_0 = 1'b1;
        after_pos();
        check("rh_held_v1", 32'(resp_valid_1), 32'd1);
        @(negedge clk);
        rst = 1'b1; req_valid_0 = 1'b0;
        after_pos();
        check("rh_rst_v1", 32'(resp_valid_1), 32'd0);
        check("rh_rst_res1", resp_result_1, 32'd0);
        check("rh_rst_v0", 32'(resp_valid_0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        #1;
        check("rh_pri_rdy0", 32'(req_ready_0), 32'd1);
        check("rh_pri_rdy1", 32'(req_ready_1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters (port 0 and port 1) using valid/ready handshakes and round-robin arbitration. Drives the ALU operand and opcode inputs and captures the ALU result into a one-entry response register per requester. Sits between the issue stage and the shared ALU instance, ahead of the writeback path.

## Interface
- `DATA_W`, default 32: operand and result width; must match the ALU.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_0` / `req_valid_1`  in  1  request present.
- `req_ready_0` / `req_ready_1`  out  1  request accepted this cycle when valid is also high.
- `req_a_0` / `req_a_1`  in  DATA_W  operand A.
- `req_b_0` / `req_b_1`  in  DATA_W  operand B.
- `req_op_0` / `req_op_1`  in  4  ALU opcode.
- `resp_valid_0` / `resp_valid_1`  out  1  response held.
- `resp_ready_0` / `resp_ready_1`  in  1  consumer takes the response.
- `resp_result_0` / `resp_result_1`  out  DATA_W  registered ALU result.
- `resp_err_0` / `resp_err_1`  out  1  illegal-opcode flag; only functional with `ALU_ARB_OPCHECK_EN`.
- `alu_a`, `alu_b`  out  DATA_W  to the shared ALU.
- `alu_op`  out  4  to the shared ALU.
- `alu_result`  in  DATA_W  from the shared ALU; combinational in the same cycle.

## Operation
- **Opcode encoding.** ADD 0000, SUB 1000, SLL 0001, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. All other codes are illegal, including 0010 and 0011.
- **Eligibility.** `elig_k = !resp_valid_k || resp_ready_k`, i.e. the slot is empty or draining this cycle.
- **Priority pointer `pri`.** One bit; reset value 0.
- **Ready.** `req_ready_k = elig_k && (pri==k || !(req_valid_j && elig_j))`, where j is the other port.
  - `req_ready_k` must not depend on `req_valid_k`.
  - At most one grant per cycle.
- **Grant.** `grant_k = req_valid_k && req_ready_k`.
- **ALU drive.**
  - On grant, `alu_a`/`alu_b`/`alu_op` carry the granted port's fields.
  - With no grant, they carry port `pri`'s fields and nothing is captured.
- **Capture on `grant_k`.** `resp_result_k <= alu_result`, `resp_valid_k <= 1`, `pri <= j`.
- **Drain.** On `resp_valid_k && resp_ready_k` without a new `grant_k`, `resp_valid_k <= 0`. The result register holds its last value.
- **Simultaneous drain and grant on the same port.** The new response replaces the old and `resp_valid_k` stays 1, giving full throughput.
- **No grant.** `pri` unchanged.

## Timing
- **Reset values.**
  - `resp_valid_*` = 0, `resp_result_*` = 0, `resp_err_*` = 0, `pri` = 0.
  - Ready outputs follow combinationally from these.
- **Latency.** Accept at clock edge N gives `resp_valid_k` high from cycle N+1.
- **Throughput.**
  - One accept per cycle total.
  - Each port sustains one per cycle when it is the sole requester and its consumer holds `resp_ready` high.
- **Backpressure.** A full slot with `resp_ready_k` low forces `req_ready_k` = 0. The other port may then be granted regardless of `pri`.
- **Reset mid-operation.** Held responses are discarded without a handshake and `pri` returns to 0. Requesters must reissue.
- **Stability.** Response outputs are registered and remain stable while `resp_valid_k && !resp_ready_k`.

## Configuration
- **`ALU_ARB_OPCHECK_EN` defined.**
  - A granted request with an illegal opcode is still accepted.
  - Captures `resp_result_k` = 0 and `resp_err_k` = 1.
  - Legal opcodes capture `resp_err_k` = 0.
  - `resp_err_k` updates only on capture.
- **Not defined.**
  - Opcode is passed through unchecked and the ALU result is captured as-is.
  - `resp_err_*` tied to 0.

## Test plan
- **Reset.** Assert `rst` 2 cycles with both `req_valid` high. Response: no `resp_valid` during reset; first grant goes to port 0 in the cycle after release.
- **Contention.** Both ports valid every cycle, both `resp_ready` high. Port 0 is 5+3 ADD, port 1 is 9-4 SUB. Response:
  - grants alternate 0,1,0,1;
  - `resp_result_0` = 8 and `resp_result_1` = 5, each one cycle after its accept.
- **Backpressure.** Port 0 issues 0xF0 AND 0x3C with `resp_ready_0` low.
  - `resp_result_0` = 0x30 is held.
  - `req_ready_0` stays 0 while port 1 is still granted every cycle.
  - Raising `resp_ready_0` re-enables port 0 in the same cycle.
- **Full throughput.** Port 1 alone issues 4 back-to-back SRA ops on 0x80000000 by 1,2,3,4 with `resp_ready_1` high. Response: 4 consecutive `resp_valid_1` cycles with results 0xC0000000, 0xE0000000, 0xF0000000, 0xF8000000.
- **Opcode check.** Port 0 issues opcode 0010.
  - With `ALU_ARB_OPCHECK_EN`: `resp_result_0` = 0 and `resp_err_0` = 1.
  - Without it: `resp_result_0` equals `alu_result` and `resp_err_0` = 0.
- **Reset with a held response.** `rst` pulsed while `resp_valid_1` = 1 and `resp_ready_1` low. Response: next cycle `resp_valid_1` = 0, `resp_result_1` = 0, and port 0 is favoured.
